mem_stage_sram_ctrl: RTL and testbench

- Consumer end of the EXE->MEM pipeline register.
- Takes mem_r_en / mem_w_en, alu_res (byte address) and val_Rm (store data) and performs 32-bit loads/stores on an external 16-bit asynchronous SRAM as two half-word accesses.
- Holds ready low for the whole multi-cycle access; the hazard/freeze logic uses it to stall every pipeline register.
- Returns load data to the MEM->WB register.

---
 rtl/mem_stage_sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage controller that performs 32-bit loads and
// stores on a 16-bit asynchronous SRAM as two timed half-word phases.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   mem_r_en/mem_w_en load / store request (store wins if both are set)
//   alu_res, val_Rm   byte address, store data
//   ready             low while an access is in flight (pipeline freeze)
//   rd_data           load result, updated by loads only
//   addr_err          one-cycle pulse on a rejected access
//   sram_*            SRAM pad signals (address, data, output enables, strobes)
//
// Optional feature: define MEM_ADDR_CHECK_EN to reject accesses below
// BASE_ADDR or beyond the SRAM. When it is undefined, addresses wrap and
// addr_err stays 0.

module mem_stage_sram_ctrl #(
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            alu_res,
    input  logic [31:0]            val_Rm,
    output logic                   ready,
    output logic [31:0]            rd_data,
    output logic                   addr_err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST    = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] LAST_WE = CW'(WAIT_CYCLES - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   is_store;
    logic                   store_nxt;
    logic                   phase_nxt;
    logic                   req;
    logic                   bad;
    logic [31:0]            off;
    logic [SRAM_ADDR_W-2:0] word;
    logic                   unused_bits;

    assign req   = mem_r_en | mem_w_en;
    assign ready = ~req | (state == DONE);

    assign off  = alu_res - 32'(BASE_ADDR);
    assign word = off[SRAM_ADDR_W:2];

    assign unused_bits = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

`ifdef MEM_ADDR_CHECK_EN
    assign bad = (alu_res < 32'(BASE_ADDR)) ||
                 (off[31:SRAM_ADDR_W+1] != '0);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = '0;
                    state_nxt = bad ? DONE : LO;
                end
            end
            LO: begin
                if (cnt == LAST) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HI: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pad controls are registered from the next state so they are clean
    // and stable for the whole phase.
    assign store_nxt = (state == IDLE) ? mem_w_en : is_store;
    assign phase_nxt = (state_nxt == LO) || (state_nxt == HI);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_store    <= 1'b0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                is_store <= mem_w_en;
            end
            sram_dq_oe <= phase_nxt && store_nxt;
            // Strobe releases one cycle before the phase ends so address
            // and data hold across its rising edge.
            sram_we_n  <= !(phase_nxt && store_nxt && cnt_nxt <= LAST_WE);
            sram_oe_n  <= !(phase_nxt && !store_nxt);
            if (state_nxt == LO && state != LO) begin
                sram_addr   <= {word, 1'b0};
                sram_dq_out <= val_Rm[15:0];
            end
            if (state_nxt == HI && state != HI) begin
                sram_addr   <= {word, 1'b1};
                sram_dq_out <= val_Rm[31:16];
            end
            if (state == LO && cnt == LAST && !is_store) begin
                rd_data[15:0] <= sram_dq_in;
            end
            if (state == HI && cnt == LAST && !is_store) begin
                rd_data[31:16] <= sram_dq_in;
            end
`ifdef MEM_ADDR_CHECK_EN
            if (state == IDLE && req && bad && !mem_w_en) begin
                rd_data <= '0;
            end
`endif
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state == IDLE) && req && bad;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed bench for mem_stage_sram_ctrl with an
// SRAM model and a scoreboard monitor comparing each completed access.

module tb_mem_stage_sram_ctrl;

    localparam int AW = 18;
    localparam int W  = 5;

    logic          clk;
    logic          rst;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [31:0]   alu_res;
    logic [31:0]   val_Rm;
    logic          ready;
    logic [31:0]   rd_data;
    logic          addr_err;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;

    int tests = 0;
    int fails = 0;

    mem_stage_sram_ctrl #(
        .SRAM_ADDR_W(AW),
        .WAIT_CYCLES(W),
        .BASE_ADDR(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en),
        .alu_res(alu_res),
        .val_Rm(val_Rm),
        .ready(ready),
        .rd_data(rd_data),
        .addr_err(addr_err),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: write latched on the rising edge of WE.
    logic [15:0] mem [logic [AW-1:0]];

    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

    always @(posedge sram_we_n) begin
        if (sram_dq_oe) mem[sram_addr] = sram_dq_out;
    end

    typedef struct {
        logic [31:0]   rd;
        int            lat;
        int            we_lo;
        int            oe_lo;
        int            dqoe;
        bit            chk_addr;
        logic [AW-1:0] a_lo;
        logic [AW-1:0] a_hi;
        logic          err;
    } exp_t;

    exp_t q[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: accumulates per-access observations, compares on ready.
    int            m_lat = 0;
    int            m_we = 0;
    int            m_oe = 0;
    int            m_dq = 0;
    logic [AW-1:0] m_alo = '0;
    logic [AW-1:0] m_ahi = '0;

    always @(negedge clk) begin
        if (!rst) begin
            m_lat = 0; m_we = 0; m_oe = 0; m_dq = 0;
        end else if (mem_r_en | mem_w_en) begin
            if (!sram_we_n) m_we++;
            if (!sram_oe_n) m_oe++;
            if (sram_dq_oe) m_dq++;
            if (!ready) begin
                m_lat++;
                if (m_lat == 2) m_alo = sram_addr;
                if (m_lat == W + 2) m_ahi = sram_addr;
            end else begin
                if (q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rd_data", rd_data, e.rd);
                    check("ready_low_cycles", m_lat, e.lat);
                    check("we_n_low_cycles", m_we, e.we_lo);
                    check("oe_n_low_cycles", m_oe, e.oe_lo);
                    check("dq_oe_cycles", m_dq, e.dqoe);
                    check("addr_err", addr_err, e.err);
                    if (e.chk_addr) begin
                        check("addr_lo", m_alo, e.a_lo);
                        check("addr_hi", m_ahi, e.a_hi);
                    end
                end
                m_lat = 0; m_we = 0; m_oe = 0; m_dq = 0;
            end
        end
    end

    function automatic exp_t mk(input bit st, input logic [31:0] rd,
                                input logic [AW-1:0] alo);
        exp_t e;
        e.rd       = rd;
        e.lat      = 2 * W + 1;
        e.we_lo    = st ? 2 * (W - 1) : 0;
        e.oe_lo    = st ? 0 : 2 * W;
        e.dqoe     = st ? 2 * W : 0;
        e.chk_addr = 1'b1;
        e.a_lo     = alo;
        e.a_hi     = alo + 1'b1;
        e.err      = 1'b0;
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge leaving DONE.
    task automatic run(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e);
        bit done;
        mem_w_en = wr;
        mem_r_en = rd;
        alu_res  = a;
        val_Rm   = d;
        q.push_back(e);
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) mem[AW'(i)] = 16'hA000 | 16'(i);
        mem[18'h3FE80] = 16'h1111;
        mem[18'h3FE81] = 16'h2222;

        rst      = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        alu_res  = '0;
        val_Rm   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_rd_data", rd_data, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_pads", {sram_dq_oe, sram_we_n, sram_oe_n, addr_err}, 4'b0110);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_pads", {sram_dq_oe, sram_we_n, sram_oe_n}, 3'b011);
        end
        @(posedge clk);
        #1;

        run(1, 0, 32'd1024, 32'hDEADBEEF, mk(1, 32'h0, 18'd0));
        check("mem_hw0", mem[18'd0], 16'hBEEF);
        check("mem_hw1", mem[18'd1], 16'hDEAD);
        @(posedge clk);
        #1;
        run(0, 1, 32'd1024, 32'h0, mk(0, 32'hDEADBEEF, 18'd0));
        @(posedge clk);
        #1;

        run(1, 0, 32'd1028, 32'h12345678, mk(1, 32'hDEADBEEF, 18'd2));
        run(0, 1, 32'd1028, 32'h0, mk(0, 32'h12345678, 18'd2));
        check("mem_hw2", mem[18'd2], 16'h5678);
        check("mem_hw3", mem[18'd3], 16'h1234);

        run(1, 1, 32'd1040, 32'hA5A55A5A, mk(1, 32'h12345678, 18'd8));
        check("mem_hw8", mem[18'd8], 16'h5A5A);
        check("mem_hw9", mem[18'd9], 16'hA5A5);
        run(0, 1, 32'd1043, 32'h0, mk(0, 32'hA5A55A5A, 18'd8));
        run(0, 1, 32'd1060, 32'h0, mk(0, 32'hA013A012, 18'd18));

`ifdef MEM_ADDR_CHECK_EN
        e          = mk(0, 32'h0, 18'd0);
        e.lat      = 1;
        e.oe_lo    = 0;
        e.chk_addr = 1'b0;
        e.err      = 1'b1;
        run(0, 1, 32'h100, 32'h0, e);
`else
        run(0, 1, 32'h100, 32'h0, mk(0, 32'h22221111, 18'h3FE80));
`endif

        // Abort a store in the middle of its high phase.
        mem_w_en = 1'b1;
        alu_res  = 32'd1032;
        val_Rm   = 32'hCAFEF00D;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("hi_addr", sram_addr, 18'd5);
        check("hi_we_n", sram_we_n, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", ready, 0);
        check("abort_rd_data", rd_data, 0);
        check("abort_sram_addr", sram_addr, 0);
        check("abort_dq_out", sram_dq_out, 0);
        check("abort_pads", {sram_dq_oe, sram_we_n, sram_oe_n, addr_err}, 4'b0110);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_w_en = 1'b0;
        check("abort_mem_hw4", mem[18'd4], 16'hF00D);
        check("abort_mem_hw5", mem[18'd5], 16'hA005);
        @(posedge clk);
        #1;
        run(0, 1, 32'd1024, 32'h0, mk(0, 32'hDEADBEEF, 18'd0));

        repeat (3) @(posedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
